// File: rtl/alu_mul_seq.sv
// Sequential 32x32->32 unsigned multiplier that drives the external single-cycle ALU with shift-and-add.
// Optional build macro EARLY_TERM_EN: leave CALC as soon as no multiplier bits remain.
module alu_mul_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             set_status_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       status_o,
    output logic [WIDTH-1:0] alu_data1_o,
    output logic [WIDTH-1:0] alu_data2_o,
    output logic [1:0]       alu_opcode_o,
    output logic             alu_signed_o,
    output logic             alu_set_status_o,
    input  logic [WIDTH-1:0] alu_data_i,
    input  logic [3:0]       alu_status_i
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_FLAGS = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_MOV = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             set_st_q, set_st_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       status_q, status_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             last_iter;
    logic             unused_alu_cv;

    // The ALU's own C/V are not meaningful for a multiply and are never forwarded.
    assign unused_alu_cv = ^alu_status_i[1:0];

    always_comb begin
        state_d          = state_q;
        acc_d            = acc_q;
        mcand_d          = mcand_q;
        mplier_d         = mplier_q;
        cnt_d            = cnt_q;
        set_st_d         = set_st_q;
        result_d         = result_q;
        status_d         = status_q;
        alu_data1_o      = '0;
        alu_data2_o      = '0;
        alu_opcode_o     = OP_MOV;
        alu_set_status_o = 1'b0;

        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef EARLY_TERM_EN
        last_iter = last_iter || (mplier_q[WIDTH-1:1] == '0);
`else
        last_iter = last_iter;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mcand_d  = op_a_i;
                    mplier_d = op_b_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                    set_st_d = set_status_i;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                alu_opcode_o = OP_ADD;
                alu_data1_o  = acc_q;
                alu_data2_o  = mcand_q;
                if (mplier_q[0]) begin
                    acc_d = alu_data_i;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d = S_FLAGS;
                end
            end
            S_FLAGS: begin
                // A MOV of the accumulator makes the ALU derive N/Z of the final product.
                alu_opcode_o     = OP_MOV;
                alu_data2_o      = acc_q;
                alu_set_status_o = 1'b1;
                result_d         = alu_data_i;
                if (set_st_q) begin
                    status_d = {alu_status_i[3], alu_status_i[2], 1'b0, 1'b0};
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_CALC) || (state_d == S_FLAGS);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            set_st_q <= 1'b0;
            result_q <= '0;
            status_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            set_st_q <= set_st_d;
            result_q <= result_d;
            status_q <= status_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign result_o     = result_q;
    assign status_o     = status_q;
    assign alu_signed_o = 1'b0;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq with a behavioural ALU; honours EARLY_TERM_EN for latency.
module tb_alu_mul_seq;

    typedef struct {
        logic [31:0] prod;
        logic        ss;
        int unsigned lat;
        int unsigned s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] op_a, op_b;
    logic        set_status;
    logic        busy, done;
    logic [31:0] result;
    logic [3:0]  status;
    logic [31:0] alu_d1, alu_d2, alu_data;
    logic [1:0]  alu_op;
    logic        alu_sgn, alu_set;
    logic [3:0]  alu_status;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;
    exp_t        sb[$];
    logic [31:0] mdl_result = '0;
    logic [3:0]  mdl_status = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_mul_seq #(.WIDTH(32), .CNT_W(5)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .op_a_i          (op_a),
        .op_b_i          (op_b),
        .set_status_i    (set_status),
        .busy_o          (busy),
        .done_o          (done),
        .result_o        (result),
        .status_o        (status),
        .alu_data1_o     (alu_d1),
        .alu_data2_o     (alu_d2),
        .alu_opcode_o    (alu_op),
        .alu_signed_o    (alu_sgn),
        .alu_set_status_o(alu_set),
        .alu_data_i      (alu_data),
        .alu_status_i    (alu_status)
    );

    // Behavioural ALU; C and V are forced high so their clearing is observable.
    always_comb begin
        alu_data = '0;
        case (alu_op)
            2'd0: alu_data = alu_d1 + alu_d2;
            2'd1: alu_data = alu_d1 - alu_d2;
            2'd2: alu_data = alu_d2;
            default: alu_data = alu_d1 << alu_d2[4:0];
        endcase
        alu_status = {alu_data[31], alu_data == 32'd0, 1'b1, 1'b1};
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int unsigned exp_lat(input logic [31:0] b);
`ifdef EARLY_TERM_EN
        int unsigned calc = 1;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) calc = i + 1;
        end
        return calc + 2;
`else
        return 34;
`endif
    endfunction

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            check_eq("alu_signed", {31'd0, alu_sgn}, 32'd0);
            if (sb.size() == 0) begin
                check_eq("idle_busy", {31'd0, busy}, 32'd0);
                check_eq("idle_done", {31'd0, done}, 32'd0);
                check_eq("idle_result", result, mdl_result);
                check_eq("idle_status", {28'd0, status}, {28'd0, mdl_status});
            end else begin
                exp_t        e;
                int unsigned k;
                logic [3:0]  st;
                e = sb[0];
                k = cyc - e.s;
                check_eq("busy", {31'd0, busy}, {31'd0, (k >= 1 && k < e.lat)});
                check_eq("done", {31'd0, done}, {31'd0, (k == e.lat)});
                if (k < e.lat) begin
                    check_eq("hold_result", result, mdl_result);
                    check_eq("hold_status", {28'd0, status}, {28'd0, mdl_status});
                end else begin
                    st = e.ss ? {e.prod[31], e.prod == 32'd0, 2'b00} : mdl_status;
                    check_eq("result", result, e.prod);
                    check_eq("status", {28'd0, status}, {28'd0, st});
                    mdl_result = e.prod;
                    mdl_status = st;
                    void'(sb.pop_front());
                end
            end
        end
    end

    // pulse_k / rst_k: cycle number (>=1) after acceptance at which to pulse start / assert reset; 0 = never.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic ss,
                         input int unsigned pulse_k, input int unsigned rst_k);
        exp_t        e;
        int unsigned k;
        logic        timed_out;
        @(negedge clk);
        op_a = a;
        op_b = b;
        set_status = ss;
        start = 1'b1;
        e.prod = a * b;
        e.ss   = ss;
        e.lat  = exp_lat(b);
        e.s    = cyc;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        set_status = ~ss;
        timed_out = 1'b1;
        for (int n = 0; n < 60; n++) begin
            if (sb.size() == 0) begin
                timed_out = 1'b0;
                break;
            end
            k = cyc - e.s;
            start = (k == pulse_k);
            if (k == rst_k) begin
                rst = 1'b1;
                start = 1'b0;
                sb.delete();
                mdl_result = '0;
                mdl_status = '0;
                @(negedge clk);
                rst = 1'b0;
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (timed_out) check_eq("sb_drain", sb.size(), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        op_a = '0;
        op_b = '0;
        set_status = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        do_op(32'd6, 32'd7, 1'b1, 0, 0);
        do_op(32'd5, 32'd0, 1'b1, 0, 0);
        do_op(32'hFFFF_FFFF, 32'd2, 1'b1, 0, 0);
        do_op(32'h0001_0000, 32'h0001_0000, 1'b1, 0, 0);
        do_op(32'h8000_0000, 32'd1, 1'b1, 0, 0);
        do_op(32'd3, 32'd3, 1'b0, 2, 0);
        do_op(32'h0000_1234, 32'h8000_0001, 1'b1, 0, 10);
        do_op(32'd6, 32'd7, 1'b0, 0, 0);
        do_op(32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            do_op($urandom, $urandom >> $urandom_range(0, 31), 1'($urandom_range(0, 1)), 0, 0);
        end
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
